// File: rtl/dev_bus_initiator.sv
// Device-bus initiator: writes operands A/B into an accelerator window, reads back
// the result, and hands it to the consumer. Each bus transfer is bounded by a timeout.
module dev_bus_initiator #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'hC4100000,
    parameter int              TIMEOUT   = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [XLEN-1:0] cmd_a_i,
    input  logic [XLEN-1:0] cmd_b_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_data_o,
    output logic            res_err_o,
    output logic            busy_o,
    output logic            en_o,
    output logic            we_o,
    output logic [XLEN-1:0] addr_o,
    output logic [XLEN-1:0] data_o,
    input  logic            ready_i,
    input  logic [XLEN-1:0] data_i
);
    localparam int              CW     = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0]   TMO    = CW'(TIMEOUT);
    localparam logic [XLEN-1:0] ADDR_A = BASE_ADDR;
    localparam logic [XLEN-1:0] ADDR_B = BASE_ADDR + XLEN'(4);
    localparam logic [XLEN-1:0] ADDR_R = BASE_ADDR + XLEN'(8);

    typedef enum logic [2:0] {IDLE, WR_A, GAP_A, WR_B, GAP_B, RD_RES, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            en_q, en_d, we_q, we_d, res_err_q, res_err_d;
    logic [XLEN-1:0] addr_q, addr_d, data_q, data_d, b_q, b_d, res_data_q, res_data_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // Bus outputs are computed for the next state so that they leave the flops
    // already valid and stay untouched while a transfer waits for ready_i.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        en_d       = en_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = WR_A;
                    b_d     = cmd_b_i;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_A;
                    data_d  = cmd_a_i;
                    wait_d  = '0;
                end
            end
            WR_A, WR_B, RD_RES: begin
                // wait_q counts ready-less cycles; a ready_i seen while it equals
                // TIMEOUT still completes the transfer.
                if (ready_i || wait_q == TMO) begin
                    en_d   = 1'b0;
                    we_d   = 1'b0;
                    addr_d = '0;
                    data_d = '0;
                    if (!ready_i) begin
                        state_d    = RESP;
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                    end else if (state_q == WR_A) begin
                        state_d = GAP_A;
                    end else if (state_q == WR_B) begin
                        state_d = GAP_B;
                    end else begin
                        state_d    = RESP;
                        res_data_d = data_i;
                        res_err_d  = 1'b0;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            GAP_A: begin
                state_d = WR_B;
                en_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = ADDR_B;
                data_d  = b_q;
                wait_d  = '0;
            end
            GAP_B: begin
                state_d = RD_RES;
                en_d    = 1'b1;
                we_d    = 1'b0;
                addr_d  = ADDR_R;
                data_d  = '0;
                wait_d  = '0;
            end
            RESP: begin
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o = (state_q == IDLE) && !rst_i;
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == RESP);
    assign res_data_o  = res_data_q;
    assign res_err_o   = res_err_q;
    assign en_o        = en_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
endmodule

// File: tb/tb_dev_bus_initiator.sv
// Directed bench for dev_bus_initiator: a negedge responder model plus scoreboard
// queues of expected bus transfers and results.
module tb_dev_bus_initiator;
    localparam logic [31:0] BASE = 32'hC4100000;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, res_valid, res_ready, res_err, busy;
    logic        en_o, we_o, ready_i;
    logic [31:0] cmd_a, cmd_b, res_data, addr_o, data_o, data_i;

    dev_bus_initiator dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_err_o(res_err), .busy_o(busy),
        .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
        .ready_i(ready_i), .data_i(data_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
    typedef struct packed { logic err; logic [31:0] data; } res_t;

    bus_t        bus_q[$];
    res_t        res_q[$];
    int          n_cmp = 0, n_err = 0;
    int          dly_a = 1, dly_b = 1, dly_r = 1;
    int          rcnt = 0, wrb_cycles = 0;
    logic [31:0] rd_value = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responder: ready_i rises d cycles after en_o is first seen (d<0: never).
    always @(negedge clk) begin
        int   d;
        bus_t e;
        if (rst || !en_o || ready_i) begin
            ready_i = 1'b0;
            data_i  = 32'h0;
            rcnt    = 0;
        end else begin
            d = (addr_o == BASE) ? dly_a : (addr_o == BASE + 32'd4) ? dly_b : dly_r;
            if (d >= 0 && rcnt >= d) begin
                ready_i = 1'b1;
                data_i  = we_o ? 32'h0 : rd_value;
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_addr", {32'h0, addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_we", {63'h0, we_o}, {63'h0, e.we});
                    chk("bus_addr", {32'h0, addr_o}, {32'h0, e.addr});
                    chk("bus_data", {32'h0, data_o}, {32'h0, e.data});
                end
            end else begin
                rcnt++;
            end
        end
    end

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] rd, input bit tmo);
        bus_q.push_back('{we: 1'b1, addr: BASE, data: a});
        bus_q.push_back('{we: 1'b1, addr: BASE + 32'd4, data: b});
        if (!tmo) bus_q.push_back('{we: 1'b0, addr: BASE + 32'd8, data: 32'h0});
        res_q.push_back(tmo ? '{err: 1'b1, data: 32'h0} : '{err: 1'b0, data: rd});
    endtask

    // Drive one command at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rd, input bit tmo);
        @(negedge clk);
        push_cmd(a, b, rd, tmo);
        rd_value  = rd;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input int limit, output int edges);
        res_t e;
        edges      = 0;
        wrb_cycles = 0;
        while (!res_valid && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (en_o && we_o && addr_o == BASE + 32'd4) wrb_cycles++;
        end
        chk("res_valid_seen", {63'h0, res_valid}, 64'h1);
        if (res_valid) begin
            if (res_q.size() == 0) begin
                chk("res_unexpected", {32'h0, res_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = res_q.pop_front();
                chk("res_data", {32'h0, res_data}, {32'h0, e.data});
                chk("res_err", {63'h0, res_err}, {63'h0, e.err});
            end
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, r1, idle_e, acc2, r2;
        logic prev_busy, seen;
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = 32'h0; cmd_b = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        chk("rst_en", {63'h0, en_o}, 64'h0);
        chk("rst_we", {63'h0, we_o}, 64'h0);
        chk("rst_addr", {32'h0, addr_o}, 64'h0);
        chk("rst_data", {32'h0, data_o}, 64'h0);
        chk("rst_res_valid", {63'h0, res_valid}, 64'h0);
        chk("rst_res_err", {63'h0, res_err}, 64'h0);
        chk("rst_res_data", {32'h0, res_data}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", {63'h0, cmd_ready}, 64'h1);

        // Nominal command, then a stalled consumer
        issue(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
        chk("busy_in_flight", {63'h0, busy}, 64'h1);
        chk("cmd_ready_in_flight", {63'h0, cmd_ready}, 64'h0);
        wait_result(40, edges);
        chk("latency_nominal", 64'(edges), 64'd8);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("resp_hold_valid", {63'h0, res_valid}, 64'h1);
            chk("resp_hold_data", {32'h0, res_data}, 64'h40400000);
            chk("resp_hold_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        chk("no_bypass_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("cmd_ready_after_take", {63'h0, cmd_ready}, 64'h1);
        chk("res_valid_after_take", {63'h0, res_valid}, 64'h0);

        // Slow WR_B: bus held stable for the whole wait
        dly_b = 5;
        issue(32'h12345678, 32'h9ABCDEF0, 32'hCAFEF00D, 1'b0);
        wait_result(60, edges);
        chk("latency_slow_wrb", 64'(edges), 64'd12);
        chk("wrb_stable_cycles", 64'(wrb_cycles), 64'd6);
        take_result();
        dly_b = 1;

        // Read never answered: timeout
        dly_r = -1;
        issue(32'h00000001, 32'h00000002, 32'hDEADBEEF, 1'b1);
        wait_result(400, edges);
        chk("latency_timeout", 64'(edges), 64'd262);
        chk("timeout_en", {63'h0, en_o}, 64'h0);
        take_result();
        dly_r = 1;

        // Reset pulse during WR_B discards the command
        dly_b = 5;
        issue(32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = en_o && we_o && (addr_o == BASE + 32'd4);
        end
        chk("reached_wrb", {63'h0, seen}, 64'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("cmd_ready_in_rst", {63'h0, cmd_ready}, 64'h0);
        @(posedge clk);
        #1;
        chk("rst_mid_en", {63'h0, en_o}, 64'h0);
        chk("rst_mid_busy", {63'h0, busy}, 64'h0);
        bus_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | res_valid;
        end
        chk("rst_mid_no_result", {63'h0, seen}, 64'h0);
        dly_b = 1;

        // Back-to-back commands, consumer always ready
        @(negedge clk);
        push_cmd(32'hAAAA0001, 32'hBBBB0001, 32'h5A5A5A5A, 1'b0);
        push_cmd(32'hAAAA0002, 32'hBBBB0002, 32'h5A5A5A5A, 1'b0);
        rd_value  = 32'h5A5A5A5A;
        cmd_a     = 32'hAAAA0001;
        cmd_b     = 32'hBBBB0001;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_a = 32'hAAAA0002;
        cmd_b = 32'hBBBB0002;
        r1 = -1; idle_e = -1; acc2 = -1; r2 = -1;
        prev_busy = busy;
        for (int e = 1; e <= 30; e++) begin
            res_t x;
            @(posedge clk);
            #1;
            if (res_valid) begin
                if (r1 < 0) r1 = e; else if (r2 < 0) r2 = e;
                if (res_q.size() > 0) begin
                    x = res_q.pop_front();
                    chk("b2b_res_data", {32'h0, res_data}, {32'h0, x.data});
                    chk("b2b_res_err", {63'h0, res_err}, {63'h0, x.err});
                end
            end
            if (!busy && idle_e < 0) idle_e = e;
            if (busy && !prev_busy && acc2 < 0) begin
                acc2      = e;
                cmd_valid = 1'b0;
            end
            prev_busy = busy;
        end
        res_ready = 1'b0;
        chk("b2b_first_result", 64'(r1), 64'd8);
        chk("b2b_idle_edge", 64'(idle_e), 64'd9);
        chk("b2b_second_accept", 64'(acc2), 64'd10);
        chk("b2b_second_result", 64'(r2), 64'd18);
        chk("bus_leftover", 64'(bus_q.size()), 64'd0);
        chk("res_leftover", 64'(res_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
